// File: rtl/serial_out_arbiter.sv
// Purpose: round-robin share of one serial shift_register between two requesters, plus serial-rate strobe.
// Latency: start pulse the cycle after IDLE sees a request; ack the cycle after i_sr_busy falls.
// Backpressure: requests wait (level held) while a transfer is in flight; a missing busy retries the start.
module serial_out_arbiter #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4,
  parameter int BUSY_TO = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [1:0]       i_req,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  output logic [1:0]       o_ack,
  output logic             o_grant,
  output logic             o_busy,
  output logic             o_sr_clk_stb,
  output logic             o_sr_start_stb,
  output logic [WIDTH-1:0] o_sr_data,
  input  logic             i_sr_busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int TO_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  // ptr_q holds the last served requester; served_q says whether ptr_q is meaningful yet,
  // so that the very first contended grant after reset goes to requester 0.
  logic             ptr_q, ptr_d;
  logic             served_q, served_d;

  // Free-running serial strobe divider, independent of the transfer sequencing.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  // Transfer sequencing: grant, start, wait for busy (with retry), wait for done, ack.
  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    grant_d  = grant_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    served_d = served_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          if (i_req == 2'b11) begin
            grant_d = served_q & ~ptr_q;
          end else begin
            grant_d = i_req[1];
          end
          data_d  = grant_d ? i_data1 : i_data0;
          state_d = S_START;
        end
      end
      S_START: begin
        to_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_sr_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          state_d = S_START;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!i_sr_busy) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ptr_d    = grant_q;
        served_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      to_q     <= '0;
      grant_q  <= 1'b0;
      data_q   <= '0;
      ptr_q    <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      to_q     <= to_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      served_q <= served_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_sr_clk_stb   = (div_q == DIV_LAST);
    o_sr_start_stb = (state_q == S_START);
    o_busy         = (state_q != S_IDLE);
    o_ack          = {(state_q == S_ACK) & grant_q, (state_q == S_ACK) & ~grant_q};
    o_grant        = grant_q;
    o_sr_data      = data_q;
  end

endmodule

// File: tb/tb_serial_out_arbiter.sv
module tb_serial_out_arbiter;
  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;
  localparam int BUSY_TO = 4;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic [1:0]       i_req = 2'b00;
  logic [WIDTH-1:0] i_data0 = '0;
  logic [WIDTH-1:0] i_data1 = '0;
  logic [1:0]       o_ack;
  logic             o_grant;
  logic             o_busy;
  logic             o_sr_clk_stb;
  logic             o_sr_start_stb;
  logic [WIDTH-1:0] o_sr_data;
  logic             i_sr_busy = 1'b0;

  serial_out_arbiter #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .BUSY_TO(BUSY_TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req),
    .i_data0(i_data0), .i_data1(i_data1), .o_ack(o_ack), .o_grant(o_grant),
    .o_busy(o_busy), .o_sr_clk_stb(o_sr_clk_stb), .o_sr_start_stb(o_sr_start_stb),
    .o_sr_data(o_sr_data), .i_sr_busy(i_sr_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // Tracks the transfer as: active flag, owner, payload, cycles since the last start
  // pulse (0 = this cycle is a start pulse), whether busy has been seen, and ack cycle.
  int         m_cyc = 0;
  bit         m_active = 0, m_seen_busy = 0, m_acking = 0;
  int         m_since = 0, m_owner = 0, m_last = -1;
  logic [7:0] m_payload = '0;

  task automatic model_step();
    if (!i_reset_n) begin
      m_cyc = 0; m_active = 0; m_seen_busy = 0; m_acking = 0;
      m_since = 0; m_owner = 0; m_last = -1; m_payload = '0;
    end else begin
      m_cyc++;
      if (!m_active) begin
        if (i_req != 2'b00) begin
          if (i_req == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
          else                m_owner = i_req[1] ? 1 : 0;
          m_payload = (m_owner == 1) ? i_data1 : i_data0;
          m_active = 1; m_since = 0; m_seen_busy = 0; m_acking = 0;
        end
      end else if (m_acking) begin
        m_active = 0; m_acking = 0; m_last = m_owner;
      end else if (m_seen_busy) begin
        if (!i_sr_busy) m_acking = 1;
      end else if (m_since == 0) begin
        m_since = 1;
      end else if (i_sr_busy) begin
        m_seen_busy = 1;
      end else if (m_since == BUSY_TO) begin
        m_since = 0;
      end else begin
        m_since++;
      end
    end
  endtask

  // Compare process: advance the model on each edge, then check all outputs 1 time unit later.
  initial begin
    forever begin
      @(posedge i_clk);
      model_step();
      #1;
      chk("ack",      int'(o_ack), m_acking ? ((m_owner == 1) ? 2 : 1) : 0);
      chk("grant",    int'(o_grant), m_owner);
      chk("busy",     int'(o_busy), int'(m_active));
      chk("start",    int'(o_sr_start_stb),
          int'(m_active && !m_acking && !m_seen_busy && m_since == 0));
      chk("sr_data",  int'(o_sr_data), int'(m_payload));
      chk("clk_stb",  int'(o_sr_clk_stb), int'((m_cyc % CLK_DIV) == CLK_DIV - 1));
    end
  end

  // ---------------- Shift register stub ----------------
  // Loads on the start pulse, shifts MSB first on each serial strobe, busy until empty.
  // 'stuck' makes it ignore start pulses. It shares reset via the arbiter going idle.
  bit         stuck = 0;
  int         sh_left = 0;
  logic [7:0] sh_reg = '0;
  logic [7:0] shifted = '0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (!o_busy) begin
        sh_left = 0;
        i_sr_busy = 1'b0;
      end else begin
        if (sh_left > 0 && o_sr_clk_stb) begin
          shifted = {shifted[6:0], sh_reg[7]};
          sh_reg  = {sh_reg[6:0], 1'b0};
          sh_left--;
          if (sh_left == 0) begin
            i_sr_busy = 1'b0;
            chk("shifted_byte", int'(shifted), int'(m_payload));
          end
        end
        if (o_sr_start_stb && !stuck && sh_left == 0) begin
          sh_reg = o_sr_data;
          shifted = '0;
          sh_left = WIDTH;
          i_sr_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- Directed and random stimulus ----------------
  task automatic wait_ack(input int budget, output bit ok, output logic [1:0] ack);
    ok = 0;
    ack = 2'b00;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (o_ack != 2'b00) begin
        ok = 1;
        ack = o_ack;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  int count_in_window;

  task automatic count_events(input int cycles, input bit want_ack);
    count_in_window = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_clk);
      if (want_ack ? (o_ack != 2'b00) : o_sr_start_stb) count_in_window++;
    end
  endtask

  initial begin
    bit         ok;
    logic [1:0] ack;
    int         n;
    int         starts[3];
    int         ns;
    logic [1:0] exp_ack[3];
    logic [7:0] exp_dat[3];

    // Reset: two cycles low, everything zero.
    repeat (2) @(negedge i_clk);
    chk("reset_outputs", int'({o_ack, o_grant, o_busy, o_sr_clk_stb, o_sr_start_stb, o_sr_data}), 0);
    i_reset_n = 1'b1;
    // Release cycle is cycle 1 (divider 0); strobe lands on cycle 4.
    n = 1;
    for (int i = 0; i < 10 && !o_sr_clk_stb; i++) begin
      @(negedge i_clk);
      n++;
    end
    chk("first_clk_stb_cycle", n, 4);

    // Single request from requester 0.
    @(negedge i_clk);
    i_data0 = 8'hA5;
    i_req = 2'b01;
    @(negedge i_clk);
    chk("single_start_next_cycle", int'(o_sr_start_stb), 1);
    wait_ack(200, ok, ack);
    chk("single_ack_seen", int'(ok), 1);
    chk("single_ack", int'(ack), 1);
    chk("single_grant", int'(o_grant), 0);
    chk("single_shift_a5", int'(shifted), 8'hA5);
    i_req = 2'b00;
    repeat (3) @(negedge i_clk);

    // Contention from a fresh pointer: 11,22,11 with acks 01,10,01.
    do_reset();
    i_data0 = 8'h11;
    i_data1 = 8'h22;
    i_req = 2'b11;
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01;
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h11;
    for (int k = 0; k < 3; k++) begin
      wait_ack(200, ok, ack);
      chk("contend_ack_seen", int'(ok), 1);
      chk("contend_ack", int'(ack), int'(exp_ack[k]));
      chk("contend_data", int'(o_sr_data), int'(exp_dat[k]));
      if (k == 2) i_req = 2'b00;
    end
    repeat (3) @(negedge i_clk);

    // Busy timeout: stuck stub makes the start repeat every BUSY_TO+1 cycles.
    stuck = 1;
    i_data0 = 8'h3C;
    i_req = 2'b01;
    ns = 0;
    for (int i = 0; i < 60 && ns < 3; i++) begin
      @(negedge i_clk);
      if (o_sr_start_stb) begin
        starts[ns] = i;
        ns++;
      end
    end
    chk("timeout_starts_seen", ns, 3);
    chk("timeout_period_1", starts[1] - starts[0], 5);
    chk("timeout_period_2", starts[2] - starts[1], 5);
    stuck = 0;
    wait_ack(200, ok, ack);
    chk("timeout_ack", int'(ack), 1);
    i_req = 2'b00;
    count_events(60, 1);
    chk("timeout_single_ack", count_in_window, 0);

    // Drop mid-transfer: requester 1 lets go while shifting; ack still pulses, nothing follows.
    i_data1 = 8'h5A;
    i_req = 2'b10;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      ok = i_sr_busy;
    end
    chk("drop_busy_seen", int'(ok), 1);
    i_req = 2'b00;
    wait_ack(200, ok, ack);
    chk("drop_ack", int'(ack), 2);
    count_events(60, 0);
    chk("drop_no_restart", count_in_window, 0);

    // Reset while waiting for done: back to idle, no ack, data cleared.
    i_data0 = 8'h77;
    i_req = 2'b01;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      ok = i_sr_busy;
    end
    chk("rst_mid_busy_seen", int'(ok), 1);
    i_reset_n = 1'b0;
    i_req = 2'b00;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_data", int'(o_sr_data), 0);
    chk("rst_mid_ack", int'(o_ack), 0);
    count_events(60, 1);
    chk("rst_mid_no_ack", count_in_window, 0);

    // Randomized traffic: protocol-respecting requesters, occasional drops, stalls and resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      i_reset_n = ($urandom_range(799, 0) != 0);
      if ($urandom_range(99, 0) == 0) stuck = !stuck;
      for (int r = 0; r < 2; r++) begin
        if (i_req[r] && o_ack[r]) begin
          if ($urandom_range(1, 0) == 1) i_req[r] = 1'b0;
        end else if (i_req[r] && o_busy && (int'(o_grant) == r) && $urandom_range(63, 0) == 0) begin
          i_req[r] = 1'b0;
        end else if (!i_req[r] && $urandom_range(3, 0) == 0) begin
          if (r == 0) i_data0 = 8'($urandom);
          else        i_data1 = 8'($urandom);
          i_req[r] = 1'b1;
        end
      end
    end
    stuck = 0;
    i_req = 2'b00;
    repeat (80) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
